// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage pipeline hazard, forwarding and mul/div stall controller
//   in : clk, rst (async active-low), D/E/M/W register ids and write/load flags,
//        BranchD, PCSrcD, JumpD, MdStartE
//   out: StallF/StallD/FlushD, StallE/flushE, ForwardAE/BE, ForwardAD/BD,
//        MdBusy, MdDone, StallCount
module hazard_ctrl #(
  parameter int MD_LATENCY = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  RegisterRsD,
  input  logic [4:0]  RegisterRtD,
  input  logic [4:0]  RegisterRsE,
  input  logic [4:0]  RegisterRtE,
  input  logic [4:0]  WriteRegE,
  input  logic [4:0]  WriteRegM,
  input  logic [4:0]  WriteRegW,
  input  logic        RegWriteE,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        MemtoRegE,
  input  logic        MemtoRegM,
  input  logic        BranchD,
  input  logic        PCSrcD,
  input  logic        JumpD,
  input  logic        MdStartE,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushD,
  output logic        StallE,
  output logic        flushE,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        ForwardAD,
  output logic        ForwardBD,
  output logic        MdBusy,
  output logic        MdDone,
  output logic [31:0] StallCount
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_e;
  md_state_e   state_q;
  logic [7:0]  cnt_q;
  logic        md_busy_q, md_done_q;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        lwstall, brstall, mdstall, hz_stall;
  // register 0 is hardwired, so it never creates a dependency
  function automatic logic hit(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction
  always_comb begin
    ForwardAE = (RegWriteM && hit(WriteRegM, RegisterRsE)) ? 2'b10 :
                (RegWriteW && hit(WriteRegW, RegisterRsE)) ? 2'b01 : 2'b00;
    ForwardBE = (RegWriteM && hit(WriteRegM, RegisterRtE)) ? 2'b10 :
                (RegWriteW && hit(WriteRegW, RegisterRtE)) ? 2'b01 : 2'b00;
    ForwardAD = RegWriteM && hit(WriteRegM, RegisterRsD);
    ForwardBD = RegWriteM && hit(WriteRegM, RegisterRtD);
    lwstall   = MemtoRegE && (hit(WriteRegE, RegisterRsD) || hit(WriteRegE, RegisterRtD));
    brstall   = BranchD && ((RegWriteE && (hit(WriteRegE, RegisterRsD) || hit(WriteRegE, RegisterRtD))) ||
                            (MemtoRegM && (hit(WriteRegM, RegisterRsD) || hit(WriteRegM, RegisterRtD))));
    // gated by rst so an asserted reset drops the hold at once
    mdstall   = rst && (((state_q == IDLE) && MdStartE) || (state_q == BUSY));
    hz_stall  = lwstall || brstall;
    StallF    = mdstall || hz_stall;
    StallD    = StallF;
    StallE    = mdstall;
    flushE    = !mdstall && hz_stall;
    // a redirect must not discard the instruction that is being held in D
    FlushD    = (PCSrcD || JumpD) && !StallD;
    stall_cnt_d = stall_cnt_q + (StallF ? 32'd1 : 32'd0);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      md_busy_q <= 1'b0;
      md_done_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (MdStartE) begin
          state_q   <= BUSY;
          cnt_q     <= 8'(MD_LATENCY - 1);
          md_busy_q <= 1'b1;
        end
        BUSY: begin
          cnt_q <= cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_q   <= DONE;
            md_busy_q <= 1'b0;
            md_done_q <= 1'b1;
          end
        end
        DONE: begin
          state_q   <= IDLE;
          md_done_q <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          md_busy_q <= 1'b0;
          md_done_q <= 1'b0;
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt_q <= 32'd0;
    else stall_cnt_q <= stall_cnt_d;
  end
  assign MdBusy     = md_busy_q;
  assign MdDone     = md_done_q;
  assign StallCount = stall_cnt_q;
endmodule
